// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: sequences PC/IR/regfile/ALU/memory controls per instruction.
// Latency: R 4, lw 5, sw 4, beq/bne 3, j 3, jal 3, imm 4 cycles with memory always ready.
// Backpressure: IF/MEM_R/MEM_W stall on mem_ready=0 and time out to ERR; enabled by MC_CTRL_MEM_WAIT_EN.
module mc_control_unit #(
    parameter int OP_W     = 6,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pc_w,
    output logic            pc_wc,
    output logic            pc_wnc,
    output logic [1:0]      pc_src,
    output logic            mem_r,
    output logic            mem_w,
    output logic            ireg_w,
    output logic [1:0]      regdst,
    output logic            reg_w,
    output logic [1:0]      memtoreg,
    output logic            alu_srca,
    output logic [1:0]      alu_srcb,
    output logic [2:0]      alu_op,
    output logic [3:0]      state,
    output logic            illegal_op,
    output logic            mem_err
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_I     = 4'd2,
        S_MEM_R    = 4'd3,
        S_MEM2REG  = 4'd4,
        S_MEM_W    = 4'd5,
        S_EX_R     = 4'd6,
        S_ALU2REG  = 4'd7,
        S_EX_B     = 4'd8,
        S_EX_J     = 4'd9,
        S_EX_JAL   = 4'd10,
        S_EX_IMM   = 4'd11,
        S_IMM2REG  = 4'd12,
        S_ERR      = 4'd13
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    state_t state_q;
    state_t state_d;
    logic   rdy;       // effective memory-ready
    logic   timeout;   // wait budget exhausted this cycle

    assign state = state_q;

`ifdef MC_CTRL_MEM_WAIT_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              mem_err_q;

    assign rdy     = mem_ready;
    assign in_wait = (state_q == S_IF) || (state_q == S_MEM_R) || (state_q == S_MEM_W);
    assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign mem_err = mem_err_q;

    // Count stalled cycles in the current memory-facing state; any state change restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_d != state_q) begin
            wait_cnt <= '0;
        end else if (in_wait && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, only cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err_q <= 1'b0;
        end else if (timeout) begin
            mem_err_q <= 1'b1;
        end
    end
`else
    // Memory is treated as always ready: no stalls, no counter, no timeout.
    logic              unused_mem_ready;
    logic [WAIT_W-1:0] unused_wait_cfg;

    assign unused_mem_ready = mem_ready;
    assign unused_wait_cfg  = WAIT_W'(MAX_WAIT);
    assign rdy              = 1'b1;
    assign timeout          = 1'b0;
    assign mem_err          = 1'b0;
`endif

    // ALU function for the immediate ops; held through IMMtoREG since op comes from the stable IR.
    function automatic logic [2:0] imm_alu_op(input logic [OP_W-1:0] opc);
        case (opc)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            OP_SLTI: imm_alu_op = ALU_SLT;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready memory wins over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (rdy)          state_d = S_ID;
                else if (timeout) state_d = S_ERR;
            end
            S_ID: begin
                case (op)
                    OP_RTYPE:                          state_d = S_EX_R;
                    OP_LW, OP_SW:                      state_d = S_EX_I;
                    OP_BEQ, OP_BNE:                    state_d = S_EX_B;
                    OP_J:                              state_d = S_EX_J;
                    OP_JAL:                            state_d = S_EX_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EX_IMM;
                    default:                           state_d = S_IF;
                endcase
            end
            S_EX_I:    state_d = (op == OP_LW) ? S_MEM_R : S_MEM_W;
            S_MEM_R: begin
                if (rdy)          state_d = S_MEM2REG;
                else if (timeout) state_d = S_ERR;
            end
            S_MEM2REG: state_d = S_IF;
            S_MEM_W: begin
                if (rdy)          state_d = S_IF;
                else if (timeout) state_d = S_ERR;
            end
            S_EX_R:    state_d = S_ALU2REG;
            S_ALU2REG: state_d = S_IF;
            S_EX_B:    state_d = S_IF;
            S_EX_J:    state_d = S_IF;
            S_EX_JAL:  state_d = S_IF;
            S_EX_IMM:  state_d = S_IMM2REG;
            S_IMM2REG: state_d = S_IF;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_IF;   // unused codes 14/15 recover to fetch
        endcase
    end

    // Output decode: Moore per state, IF write enables qualified by ready, everything zero in reset.
    always_comb begin
        pc_w       = 1'b0;
        pc_wc      = 1'b0;
        pc_wnc     = 1'b0;
        pc_src     = 2'b00;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        ireg_w     = 1'b0;
        regdst     = 2'b00;
        reg_w      = 1'b0;
        memtoreg   = 2'b00;
        alu_srca   = 1'b0;
        alu_srcb   = 2'b00;
        alu_op     = ALU_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_IF: begin
                mem_r    = 1'b1;
                alu_srcb = 2'b01;
                pc_w     = rdy;
                ireg_w   = rdy;
            end
            S_ID: begin
                alu_srcb = 2'b11;
                case (op)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal_op = 1'b0;
                    default:                           illegal_op = 1'b1;
                endcase
            end
            S_EX_I: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
            end
            S_MEM_R: mem_r = 1'b1;
            S_MEM2REG: begin
                reg_w    = 1'b1;
                memtoreg = 2'b01;
            end
            S_MEM_W: mem_w = 1'b1;
            S_EX_R: begin
                alu_srca = 1'b1;
                alu_op   = ALU_FUNCT;
            end
            S_ALU2REG: begin
                reg_w  = 1'b1;
                regdst = 2'b01;
            end
            S_EX_B: begin
                alu_srca = 1'b1;
                alu_op   = ALU_SUB;
                pc_src   = 2'b01;
                pc_wc    = (op == OP_BEQ);
                pc_wnc   = (op == OP_BNE);
            end
            S_EX_J: begin
                pc_w   = 1'b1;
                pc_src = 2'b10;
            end
            S_EX_JAL: begin
                pc_w     = 1'b1;
                pc_src   = 2'b10;
                reg_w    = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
            end
            S_EX_IMM: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                alu_op   = imm_alu_op(op);
            end
            S_IMM2REG: begin
                reg_w  = 1'b1;
                alu_op = imm_alu_op(op);
            end
            default: ;   // ERR and unused codes: all controls low
        endcase
        if (reset) begin
            pc_w       = 1'b0;
            pc_wc      = 1'b0;
            pc_wnc     = 1'b0;
            pc_src     = 2'b00;
            mem_r      = 1'b0;
            mem_w      = 1'b0;
            ireg_w     = 1'b0;
            regdst     = 2'b00;
            reg_w      = 1'b0;
            memtoreg   = 2'b00;
            alu_srca   = 1'b0;
            alu_srcb   = 2'b00;
            alu_op     = ALU_ADD;
            illegal_op = 1'b0;
        end
    end

endmodule
